// File: rtl/program_loader.sv
// program_loader: packs a valid/ready byte stream into little-endian 32-bit
// words and writes them sequentially into program memory from address 0,
// holding the CPU stalled for the duration of the load.
module program_loader #(
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  abort,
    input  logic [7:0]            byte_data,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned LEN_W = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  word_cnt;
    logic [1:0]             byte_cnt;
    logic [31:0]            asm_word;
    logic [LEN_W-1:0]       len_q;

    logic                   len_ok;
    logic                   byte_fire;
    logic                   last_word;

    // Start qualification, handshake and end-of-load detection.
    assign len_ok    = (length != '0) && (length <= LEN_W'(DEPTH));
    assign byte_fire = byte_valid && byte_ready;
    assign last_word = ((LEN_W'(word_cnt) + LEN_W'(1)) == len_q);

    // The CPU is stalled for exactly as long as a load is in progress.
    assign cpu_hold = busy;

    // Loader FSM with registered outputs; abort returns to IDLE from any active state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            word_cnt   <= '0;
            byte_cnt   <= '0;
            asm_word   <= '0;
            len_q      <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
            if (state != IDLE && abort) begin
                state      <= IDLE;
                word_cnt   <= '0;
                byte_cnt   <= '0;
                asm_word   <= '0;
                byte_ready <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (len_ok) begin
                                len_q      <= length;
                                word_cnt   <= '0;
                                byte_cnt   <= '0;
                                asm_word   <= '0;
                                byte_ready <= 1'b1;
                                busy       <= 1'b1;
                                state      <= RECV;
                            end else begin
                                error <= 1'b1;
                            end
                        end
                    end
                    RECV: begin
                        if (byte_fire) begin
                            asm_word[{byte_cnt, 3'b000} +: 8] <= byte_data;
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3) begin
                                byte_ready <= 1'b0;
                                mem_we     <= 1'b1;
                                mem_addr   <= 32'(word_cnt);
                                mem_wdata  <= {byte_data, asm_word[23:0]};
                                state      <= WRITE;
                            end
                        end
                    end
                    WRITE: begin
                        if (last_word) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            word_cnt   <= word_cnt + ADDR_WIDTH'(1);
                            byte_ready <= 1'b1;
                            state      <= RECV;
                        end
                    end
                    DONE: begin
                        word_cnt <= '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected write/done/error
// events; a negedge monitor pops and compares whenever the DUT presents one.
module tb_program_loader;

    localparam int unsigned AW = 4;
    localparam int K_WR   = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   length;
    logic          abort;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          byte_ready;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          cpu_hold;
    logic          done;
    logic          error;

    ev_t exp_q[$];
    int  compared   = 0;
    int  mismatched = 0;

    program_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .length     (length),
        .abort      (abort),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input int kind, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_event: got kind %0d addr %h data %h expected none", kind, addr, data);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            if (e.kind == K_WR && kind == K_WR) begin
                chk("wr_addr", addr, e.addr);
                chk("wr_data", data, e.data);
            end
        end
    endtask

    // Monitor: every write, done or error pulse must match the head of the queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) pop_chk(K_WR, mem_addr, mem_wdata);
            if (done)   pop_chk(K_DONE, 32'd0, 32'd0);
            if (error)  pop_chk(K_ERR, 32'd0, 32'd0);
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_data  = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            compared++;
            mismatched++;
            $display("FAIL byte_timeout: got byte_ready 0 expected 1");
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap; g++) begin
                byte_valid = 1'b0;
                @(negedge clk);
            end
            send_byte(w[8*i +: 8]);
        end
        chk("write_latency", 32'(mem_we), 32'd1);
    endtask

    task automatic do_start(input logic [AW:0] len, input bit good);
        start  = 1'b1;
        length = len;
        @(negedge clk);
        start = 1'b0;
        if (good) begin
            chk("start_busy", 32'(busy), 32'd1);
            chk("start_hold", 32'(cpu_hold), 32'd1);
            chk("start_ready", 32'(byte_ready), 32'd1);
        end else begin
            chk("bad_error", 32'(error), 32'd1);
            chk("bad_busy", 32'(busy), 32'd0);
            @(negedge clk);
            chk("bad_error_clear", 32'(error), 32'd0);
            chk("bad_busy2", 32'(busy), 32'd0);
        end
    endtask

    task automatic expect_done();
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("done_clear", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_hold", 32'(cpu_hold), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        length     = '0;
        abort      = 1'b0;
        byte_data  = 8'h00;
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single word, back-to-back bytes.
        push_ev(K_WR, 32'd0, 32'h0000_0001);
        push_ev(K_DONE, 32'd0, 32'd0);
        do_start(5'd1, 1'b1);
        send_word(32'h0000_0001, 0);
        expect_done();

        // Full 16-word load.
        for (int i = 0; i < 16; i++) push_ev(K_WR, 32'(i), 32'(i));
        push_ev(K_DONE, 32'd0, 32'd0);
        do_start(5'd16, 1'b1);
        for (int i = 0; i < 16; i++) send_word(32'(i), 0);
        expect_done();

        // Throttled source.
        push_ev(K_WR, 32'd0, 32'hDEAD_BEEF);
        push_ev(K_DONE, 32'd0, 32'd0);
        do_start(5'd1, 1'b1);
        send_word(32'hDEAD_BEEF, 1);
        expect_done();

        // Rejected lengths.
        push_ev(K_ERR, 32'd0, 32'd0);
        do_start(5'd0, 1'b0);
        push_ev(K_ERR, 32'd0, 32'd0);
        do_start(5'd17, 1'b0);

        // Abort after six bytes of a two-word load.
        push_ev(K_WR, 32'd0, 32'h0403_0201);
        do_start(5'd2, 1'b1);
        send_word(32'h0403_0201, 0);
        send_byte(8'h55);
        send_byte(8'h66);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(byte_ready), 32'd0);
        repeat (3) @(negedge clk);
        push_ev(K_WR, 32'd0, 32'h1122_3344);
        push_ev(K_DONE, 32'd0, 32'd0);
        do_start(5'd1, 1'b1);
        send_word(32'h1122_3344, 0);
        expect_done();

        // Asynchronous reset in the middle of RECV.
        do_start(5'd1, 1'b1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(byte_ready), 32'd0);
        chk("arst_addr", mem_addr, 32'd0);
        chk("arst_wdata", mem_wdata, 32'd0);
        chk("arst_hold", 32'(cpu_hold), 32'd0);
        @(negedge clk);
        reset      = 1'b0;
        byte_data  = 8'hCC;
        byte_valid = 1'b1;
        repeat (6) @(negedge clk);
        byte_valid = 1'b0;
        chk("post_rst_ready", 32'(byte_ready), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        push_ev(K_WR, 32'd0, 32'hCAFE_F00D);
        push_ev(K_DONE, 32'd0, 32'd0);
        do_start(5'd1, 1'b1);
        send_word(32'hCAFE_F00D, 0);
        expect_done();

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
